// File: rtl/update_scan.sv
// update_scan: writer side of the element-cell scan.
// Owns DEPTH version cells. Each update request is executed by a sequential
// scan that closes the live version of the element and records the lowest
// free slot. A new cell is then allocated in that slot.
// Optional build macro INPLACE_UPDATE_EN: when the closing match has
// low == metadata, the matched cell is rewritten in place instead of being
// freed and reallocated.
module update_scan #(
  parameter int         DEPTH = 8,
  parameter logic [7:0] MAXV  = 8'hFF,
  localparam int        SW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_array_code,
  input  logic [7:0]    req_index,
  input  logic [7:0]    req_value,
  input  logic [7:0]    req_metadata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_ok,
  output logic          resp_full,
  output logic [SW-1:0] resp_slot,
  input  logic [SW-1:0] rd_addr,
  output logic          rd_arrDef,
  output logic          rd_eltDef,
  output logic [7:0]    rd_array_code,
  output logic [7:0]    rd_rank,
  output logic [7:0]    rd_low,
  output logic [7:0]    rd_high,
  output logic [7:0]    rd_index,
  output logic [7:0]    rd_value
);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, RESP} state_t;

  typedef struct packed {
    logic       arr_def;
    logic       elt_def;
    logic [7:0] array_code;
    logic [7:0] rank;
    logic [7:0] low;
    logic [7:0] high;
    logic [7:0] index;
    logic [7:0] value;
  } cell_t;

  localparam logic [SW-1:0] LAST = SW'(DEPTH - 1);

  state_t          state, state_nxt;
  cell_t           cells [DEPTH];
  cell_t           cur;
  cell_t           rd_cell;
  logic [SW-1:0]   ptr;
  logic [7:0]      rq_code, rq_index, rq_value, rq_md;
  logic            matched;
  logic            free_found;
  logic [SW-1:0]   free_slot;
  logic            hit;
  logic            hit_low;
  logic            slot_free;
`ifdef INPLACE_UPDATE_EN
  logic            inplace_hit;
  logic [SW-1:0]   inplace_slot;
`endif

  assign req_ready = (state == IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  // NOTE: every always_comb output is given a default first so no path can
  // leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)      state_nxt = SCAN;
      SCAN:    if (ptr == LAST)    state_nxt = WRITE;
      WRITE:                       state_nxt = RESP;
      RESP:    if (resp_ready)     state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Match and free-slot evaluation for the cell under the scan pointer.
  always_comb begin
    cur     = cells[ptr];
    hit     = (state == SCAN) && !matched && cur.elt_def &&
              (cur.array_code == rq_code) && (cur.index == rq_index) &&
              (cur.low <= rq_md) && (rq_md <= cur.high);
    hit_low = hit && (rq_md == cur.low);
`ifdef INPLACE_UPDATE_EN
    // A cell rewritten in place stays live, so it never counts as free.
    slot_free = !cur.elt_def;
`else
    // A cell freed by this very match is eligible as the allocation slot.
    slot_free = !cur.elt_def || hit_low;
`endif
  end

  // Request latch, scan bookkeeping, cell updates and response registers.
  // NOTE: the cells must read as zero after reset, so they are flops with an
  // explicit reset loop rather than a RAM; state updates use <= throughout so
  // every read in a cycle sees the value committed at the previous edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cells[i] <= '0;
      ptr        <= '0;
      rq_code    <= '0;
      rq_index   <= '0;
      rq_value   <= '0;
      rq_md      <= '0;
      matched    <= 1'b0;
      free_found <= 1'b0;
      free_slot  <= '0;
      resp_valid <= 1'b0;
      resp_ok    <= 1'b0;
      resp_full  <= 1'b0;
      resp_slot  <= '0;
`ifdef INPLACE_UPDATE_EN
      inplace_hit  <= 1'b0;
      inplace_slot <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rq_code    <= req_array_code;
            rq_index   <= req_index;
            rq_value   <= req_value;
            rq_md      <= req_metadata;
            ptr        <= '0;
            matched    <= 1'b0;
            free_found <= 1'b0;
            free_slot  <= '0;
`ifdef INPLACE_UPDATE_EN
            inplace_hit  <= 1'b0;
            inplace_slot <= '0;
`endif
          end
        end
        SCAN: begin
          ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
          if (hit) begin
            matched <= 1'b1;
            if (hit_low) begin
`ifdef INPLACE_UPDATE_EN
              cells[ptr].value <= rq_value;
              cells[ptr].high  <= MAXV;
              inplace_hit      <= 1'b1;
              inplace_slot     <= ptr;
`else
              cells[ptr].elt_def <= 1'b0;
`endif
            end else begin
              // rq_md > low here, so the decrement cannot wrap.
              cells[ptr].high <= rq_md - 8'd1;
            end
          end
          if (!free_found && slot_free) begin
            free_found <= 1'b1;
            free_slot  <= ptr;
          end
        end
        WRITE: begin
          resp_valid <= 1'b1;
`ifdef INPLACE_UPDATE_EN
          if (inplace_hit) begin
            resp_ok   <= 1'b1;
            resp_slot <= inplace_slot;
          end else
`endif
          if (free_found) begin
            cells[free_slot] <= '{arr_def: 1'b1, elt_def: 1'b1,
                                  array_code: rq_code, rank: rq_md,
                                  low: rq_md, high: MAXV,
                                  index: rq_index, value: rq_value};
            resp_ok   <= 1'b1;
            resp_slot <= free_slot;
          end else begin
            resp_full <= 1'b1;
            resp_slot <= '0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_ok    <= 1'b0;
            resp_full  <= 1'b0;
            resp_slot  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Combinational read port; addresses beyond the cell array read as zero.
  always_comb begin
    rd_cell = '0;
    if (32'(rd_addr) < DEPTH) rd_cell = cells[rd_addr];
  end

  assign rd_arrDef     = rd_cell.arr_def;
  assign rd_eltDef     = rd_cell.elt_def;
  assign rd_array_code = rd_cell.array_code;
  assign rd_rank       = rd_cell.rank;
  assign rd_low        = rd_cell.low;
  assign rd_high       = rd_cell.high;
  assign rd_index      = rd_cell.index;
  assign rd_value      = rd_cell.value;

endmodule

// File: tb/tb_update_scan.sv
// Directed testbench for update_scan (DEPTH = 8).
module tb_update_scan;

  localparam int DEPTH = 8;
  localparam int SW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    req_array_code = '0;
  logic [7:0]    req_index = '0;
  logic [7:0]    req_value = '0;
  logic [7:0]    req_metadata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_ok;
  logic          resp_full;
  logic [SW-1:0] resp_slot;
  logic [SW-1:0] rd_addr = '0;
  logic          rd_arrDef, rd_eltDef;
  logic [7:0]    rd_array_code, rd_rank, rd_low, rd_high, rd_index, rd_value;

  int checks = 0;
  int errors = 0;

  update_scan #(.DEPTH(DEPTH), .MAXV(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_array_code(req_array_code), .req_index(req_index),
    .req_value(req_value), .req_metadata(req_metadata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_ok(resp_ok), .resp_full(resp_full), .resp_slot(resp_slot),
    .rd_addr(rd_addr),
    .rd_arrDef(rd_arrDef), .rd_eltDef(rd_eltDef),
    .rd_array_code(rd_array_code), .rd_rank(rd_rank),
    .rd_low(rd_low), .rd_high(rd_high),
    .rd_index(rd_index), .rd_value(rd_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cell image: {arrDef, eltDef, code, rank, low, high, index, value}.
  function automatic logic [49:0] mk(input logic [7:0] code, rank, low, high, idx, val);
    return {1'b1, 1'b1, code, rank, low, high, idx, val};
  endfunction

  task automatic read_cell(input int addr, output logic [49:0] c);
    rd_addr = SW'(addr);
    #1;
    c = {rd_arrDef, rd_eltDef, rd_array_code, rd_rank, rd_low, rd_high, rd_index, rd_value};
  endtask

  task automatic check_cell(input string tag, input int addr, input logic [49:0] exp);
    logic [49:0] c;
    read_cell(addr, c);
    check(tag, 64'(c), 64'(exp));
  endtask

  // Drive one request; returns at the falling edge of the first SCAN cycle.
  task automatic start_req(input logic [7:0] code, idx, val, md);
    @(negedge clk);
    check("req_ready_before", 64'(req_ready), 64'd1);
    req_array_code = code;
    req_index      = idx;
    req_value      = val;
    req_metadata   = md;
    req_valid      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Bounded wait for resp_valid; lat counts from the accept cycle (cycle 0).
  task automatic wait_resp(input string tag);
    int lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(DEPTH + 2));
  endtask

  task automatic consume(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_valid_cleared"}, 64'(resp_valid), 64'd0);
    check({tag, "_ok_cleared"}, 64'(resp_ok), 64'd0);
    check({tag, "_ready_back"}, 64'(req_ready), 64'd1);
  endtask

  task automatic do_update(input string tag, input logic [7:0] code, idx, val, md,
                           input logic exp_ok, input logic exp_full, input int exp_slot);
    start_req(code, idx, val, md);
    wait_resp(tag);
    check({tag, "_ok"}, 64'(resp_ok), 64'(exp_ok));
    check({tag, "_full"}, 64'(resp_full), 64'(exp_full));
    check({tag, "_slot"}, 64'(resp_slot), 64'(exp_slot));
    consume(tag);
  endtask

  initial begin
    logic [49:0] c;

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_ok", 64'(resp_ok), 64'd0);
    check("rst_resp_full", 64'(resp_full), 64'd0);
    check("rst_resp_slot", 64'(resp_slot), 64'd0);
    for (int i = 0; i < DEPTH; i++) check_cell("rst_cell", i, 50'd0);

    // First version of element (3,5).
    do_update("u1", 8'd3, 8'd5, 8'hAA, 8'd2, 1'b1, 1'b0, 0);
    check_cell("u1_cell0", 0, mk(8'd3, 8'd2, 8'd2, 8'hFF, 8'd5, 8'hAA));

    // Newer version closes cell0 at md-1 and allocates slot 1.
    do_update("u2", 8'd3, 8'd5, 8'hBB, 8'd7, 1'b1, 1'b0, 1);
    check_cell("u2_cell0", 0, mk(8'd3, 8'd2, 8'd2, 8'h06, 8'd5, 8'hAA));
    check_cell("u2_cell1", 1, mk(8'd3, 8'd7, 8'd7, 8'hFF, 8'd5, 8'hBB));
    // lookUp at metadata 4: inside cell0 range, outside cell1 range.
    read_cell(0, c);
    check("lookup4_cell0", 64'((rd_low <= 8'd4) && (8'd4 <= rd_high)), 64'd1);
    read_cell(1, c);
    check("lookup4_cell1", 64'((rd_low <= 8'd4) && (8'd4 <= rd_high)), 64'd0);

    // Same metadata as the live cell's low: slot 1 is reused/rewritten.
    do_update("u3", 8'd3, 8'd5, 8'hCC, 8'd7, 1'b1, 1'b0, 1);
    check_cell("u3_cell1", 1, mk(8'd3, 8'd7, 8'd7, 8'hFF, 8'd5, 8'hCC));
    check_cell("u3_cell0", 0, mk(8'd3, 8'd2, 8'd2, 8'h06, 8'd5, 8'hAA));

    // Fill remaining slots with distinct indices.
    for (int i = 2; i < DEPTH; i++)
      do_update("fill", 8'd3, 8'(8 + i), 8'(16 + i), 8'd1, 1'b1, 1'b0, i);
    check_cell("fill_cell7", 7, mk(8'd3, 8'd1, 8'd1, 8'hFF, 8'd15, 8'h17));

    // Full: new index dropped, nothing changes.
    do_update("full1", 8'd3, 8'd20, 8'h99, 8'd1, 1'b0, 1'b1, 0);
    check_cell("full1_cell0", 0, mk(8'd3, 8'd2, 8'd2, 8'h06, 8'd5, 8'hAA));
    check_cell("full1_cell7", 7, mk(8'd3, 8'd1, 8'd1, 8'hFF, 8'd15, 8'h17));

    // Full with a match: close still applied to cell2.
    do_update("full2", 8'd3, 8'd10, 8'h77, 8'd5, 1'b0, 1'b1, 0);
    check_cell("full2_cell2", 2, mk(8'd3, 8'd1, 8'd1, 8'h04, 8'd10, 8'h12));

    // Response held with resp_ready low; req_valid pulses ignored.
    start_req(8'd3, 8'd11, 8'h55, 8'd1);
    wait_resp("hold");
    for (int k = 0; k < 10; k++) begin
      req_array_code = 8'd3;
      req_index      = 8'd12;
      req_value      = 8'h66;
      req_metadata   = 8'd9;
      req_valid      = k[0];
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_ok", 64'(resp_ok), 64'd1);
      check("hold_slot", 64'(resp_slot), 64'd3);
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    consume("hold");
    check_cell("hold_cell3", 3, mk(8'd3, 8'd1, 8'd1, 8'hFF, 8'd11, 8'h55));
    check_cell("hold_cell4", 4, mk(8'd3, 8'd1, 8'd1, 8'hFF, 8'd12, 8'h14));

    // Reset during SCAN aborts and clears everything.
    start_req(8'd3, 8'd13, 8'h44, 8'd3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    check("mid_rst_valid", 64'(resp_valid), 64'd0);
    for (int i = 0; i < DEPTH; i++) check_cell("mid_rst_cell", i, 50'd0);
    repeat (DEPTH + 4) @(negedge clk);
    check("mid_rst_no_resp", 64'(resp_valid), 64'd0);

    // Metadata 0 boundary after reset.
    do_update("md0", 8'd1, 8'd2, 8'd3, 8'd0, 1'b1, 1'b0, 0);
    check_cell("md0_cell0", 0, mk(8'd1, 8'd0, 8'd0, 8'hFF, 8'd2, 8'd3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
